nes_poll_ctrl: RTL

- Sequences a standard NES controller port: generates the latch and clock pulses, samples the serial data line, and publishes debounced-by-frame button vectors.
- Serves two controller ports that share latch and clock, with a separate data line each.
- Sits between the pad connectors and game/UI logic.
- Replaces free-running external clocking of the pad shift register with a self-timed poll engine.

---
 rtl/nes_poll_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/nes_poll_ctrl.sv
// nes_poll_ctrl: self-timed poll engine for two NES controller ports.
// Generates the shared latch/clock pulses, shifts in both serial data
// lines and publishes per-frame button and newly-pressed vectors.
module nes_poll_ctrl #(
    parameter int HALF_PERIOD = 6,     // system clocks per half controller clock (T)
    parameter int POLL_PERIOD = 1000   // system clocks between automatic polls
) (
    input  logic       clk,
    input  logic       reset,          // asynchronous, active-low
    input  logic       enable,
    input  logic       poll_req,
    input  logic       nes_data1,
    input  logic       nes_data2,
    output logic       nes_latch,
    output logic       nes_pulse,
    output logic [7:0] buttons1,
    output logic [7:0] buttons2,
    output logic [7:0] pressed1,
    output logic [7:0] pressed2,
    output logic       valid,
    output logic       busy
);

    localparam int TW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int CW = $clog2(2 * HALF_PERIOD);
    localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_PERIOD - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(2 * HALF_PERIOD - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            pending_q, pending_d;
    logic [CW-1:0]   phase_q, phase_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sr1_q, sr2_q;
    logic [7:0]      buttons1_q, buttons2_q;
    logic [7:0]      pressed1_q, pressed2_q;
    logic            valid_q;

    logic            wrap;
    logic            start;
    logic            sample_en;
    logic            publish_en;

    // Free-running period timer and the one-deep pending poll flag.
    always_comb begin
        wrap    = (timer_q == TIMER_LAST);
        timer_d = wrap ? '0 : timer_q + 1'b1;
        start   = (state_q == S_IDLE) && (pending_q || poll_req);
        // A poll that starts consumes the pending flag, but a wrap landing on
        // the same cycle must still be remembered so it is not lost.
        if (start) begin
            pending_d = wrap && enable;
        end else begin
            pending_d = pending_q || poll_req || (wrap && enable);
        end
    end

    // Poll sequencer: next state, phase/bit counters and datapath strobes.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        sample_en  = 1'b0;
        publish_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LATCH;
                    phase_d = '0;
                end
            end
            S_LATCH: begin
                if (phase_q == LATCH_LAST) begin
                    state_d = S_LOW;
                    phase_d = '0;
                    bit_d   = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_LOW: begin
                if (phase_q == HALF_LAST) begin
                    // Sample at the end of the low half, when the pad output
                    // has had the longest time to settle.
                    sample_en = 1'b1;
                    phase_d   = '0;
                    state_d   = (bit_q == 3'd7) ? S_DONE : S_HIGH;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_HIGH: begin
                if (phase_q == HALF_LAST) begin
                    phase_d = '0;
                    bit_d   = bit_q + 3'd1;
                    state_d = S_LOW;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_DONE: begin
                publish_en = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers; reset aborts any poll in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            pending_q <= 1'b0;
            phase_q   <= '0;
            bit_q     <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
        end
    end

    // Shift registers and published vectors for both pads (data is active-low).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr1_q      <= '0;
            sr2_q      <= '0;
            buttons1_q <= '0;
            buttons2_q <= '0;
            pressed1_q <= '0;
            pressed2_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= publish_en;
            if (sample_en) begin
                sr1_q <= {sr1_q[6:0], ~nes_data1};
                sr2_q <= {sr2_q[6:0], ~nes_data2};
            end
            if (publish_en) begin
                buttons1_q <= sr1_q;
                buttons2_q <= sr2_q;
                pressed1_q <= sr1_q & ~buttons1_q;
                pressed2_q <= sr2_q & ~buttons2_q;
            end
        end
    end

    // Pad strobes decode straight from the state register so an asynchronous
    // reset drops them immediately.
    assign nes_latch = (state_q == S_LATCH);
    assign nes_pulse = (state_q == S_HIGH);
    assign busy      = (state_q != S_IDLE);
    assign valid     = valid_q;
    assign buttons1  = buttons1_q;
    assign buttons2  = buttons2_q;
    assign pressed1  = pressed1_q;
    assign pressed2  = pressed2_q;

endmodule
